// File: rtl/ps2_pkg.sv
// Shared types, frame layout constants and the parity helper for the PS/2 receiver.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, RECV, CHECK} ps2_state_e;

   localparam int FRAME_DATA_BITS = 8;
   localparam int PARITY_IDX      = 8;
   localparam int STOP_IDX        = 9;

   function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                          input logic                       parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises ps2_clk/ps2_data and debounces ps2_clk; emits a one-cycle strobe on
// each filtered falling edge.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall_strobe,
   output logic data_sync
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_sync_q, clk_sync_d;
   logic [1:0]    data_sync_q, data_sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          level_prev_q, level_prev_d;

   always_comb begin
      clk_sync_d   = {clk_sync_q[0], ps2_clk};
      data_sync_d  = {data_sync_q[0], ps2_data};
      cnt_d        = '0;
      level_d      = level_q;
      level_prev_d = level_q;
      // Any sample matching the current level restarts the run count.
      if (clk_sync_q[1] != level_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q   <= 2'b11;
         data_sync_q  <= 2'b11;
         cnt_q        <= '0;
         level_q      <= 1'b1;
         level_prev_q <= 1'b1;
      end else begin
         clk_sync_q   <= clk_sync_d;
         data_sync_q  <= data_sync_d;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
      end
   end

   assign fall_strobe = level_prev_q & ~level_q;
   assign data_sync   = data_sync_q[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: frame deserialiser, checker, one-entry holding
// register and clock-line inhibit while that register is full.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       code_ready,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       ps2_clk_pulldown
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic fall_strobe, data_s;

   ps2_state_e                 state_q, state_d;
   logic [3:0]                 bitcnt_q, bitcnt_d;
   logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
   logic                       parity_q, parity_d;
   logic                       stop_q, stop_d;
   logic [TW-1:0]              tmo_q, tmo_d;
   logic [7:0]                 code_q, code_d;
   logic                       code_valid_q, code_valid_d;
   logic                       frame_err_q, frame_err_d;
   logic                       overrun_q, overrun_d;
   logic                       pulldown_q, pulldown_d;
   logic                       good;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .fall_strobe (fall_strobe),
      .data_sync   (data_s)
   );

   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      stop_d       = stop_q;
      tmo_d        = tmo_q;
      code_d       = code_q;
      code_valid_d = code_valid_q;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      good         = odd_parity_ok(shift_q, parity_q) && stop_q;

      if (code_valid_q && code_ready) code_valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            tmo_d    = '0;
            bitcnt_d = '0;
            if (fall_strobe) begin
               if (!data_s) state_d = RECV;
               else         frame_err_d = 1'b1;
            end
         end
         RECV: begin
            if (fall_strobe) begin
               tmo_d    = '0;
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q < 4'(FRAME_DATA_BITS)) begin
                  shift_d = {data_s, shift_q[FRAME_DATA_BITS-1:1]};
               end else if (bitcnt_q == 4'(PARITY_IDX)) begin
                  parity_d = data_s;
               end else if (bitcnt_q == 4'(STOP_IDX)) begin
                  stop_d  = data_s;
                  state_d = CHECK;
               end
            // Counter starts at 0 the cycle after the strobe and the error is
            // registered, so T-2 lands the pulse TIMEOUT_CYCLES after the edge.
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (good) begin
               if (!code_valid_q || code_ready) begin
                  code_d       = shift_q;
                  code_valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      pulldown_d = (state_d == IDLE) && code_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bitcnt_q     <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         stop_q       <= 1'b0;
         tmo_q        <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         pulldown_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         stop_q       <= stop_d;
         tmo_q        <= tmo_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         pulldown_q   <= pulldown_d;
      end
   end

   assign code             = code_q;
   assign code_valid       = code_valid_q;
   assign frame_err        = frame_err_q;
   assign overrun          = overrun_q;
   assign ps2_clk_pulldown = pulldown_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: bit-banged PS/2 frames, expected codes queued at send time.
module tb_ps2_rx;

   localparam int FILT = 8;
   localparam int TMO  = 1000;
   localparam int HALF = 30;

   logic       clk = 1'b0;
   logic       rst, ps2_clk, ps2_data, code_ready;
   logic [7:0] code;
   logic       code_valid, frame_err, overrun, ps2_clk_pulldown;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_fall = 0;
   int err_cnt = 0, ovr_cnt = 0, vld_cyc = 0;
   logic [7:0] sb[$];
   logic       prev_hold = 1'b0;
   logic [7:0] prev_code = '0;

   ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .rst              (rst),
      .ps2_clk          (ps2_clk),
      .ps2_data         (ps2_data),
      .code_ready       (code_ready),
      .code             (code),
      .code_valid       (code_valid),
      .frame_err        (frame_err),
      .overrun          (overrun),
      .ps2_clk_pulldown (ps2_clk_pulldown)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Output monitor: consumes scoreboard entries on each handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) err_cnt++;
         if (overrun)   ovr_cnt++;
         if (code_valid) vld_cyc++;
         if (frame_err || overrun) begin
            total++;
            if (frame_err && overrun) begin
               bad++;
               $display("FAIL err_and_overrun: both asserted at cycle %0d", cyc);
            end
         end
         if (code_valid && code_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got code %02h, nothing expected", code);
            end else begin
               logic [7:0] exp;
               exp = sb.pop_front();
               if (code !== exp) begin
                  bad++;
                  $display("FAIL sb_code: got %02h expected %02h", code, exp);
               end
            end
         end
         if (prev_hold) begin
            total++;
            if (code !== prev_code) begin
               bad++;
               $display("FAIL code_stable: got %02h expected %02h", code, prev_code);
            end
         end
         prev_hold = code_valid && !code_ready;
         prev_code = code;
      end else begin
         prev_hold = 1'b0;
      end
   end

   function automatic logic par_of(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ps2_bit(input logic b, input logic glitch);
      ps2_data = b;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      if (glitch) begin
         wait_cyc(10);
         ps2_clk = 1'b0;
         wait_cyc(3);
         ps2_clk = 1'b1;
         wait_cyc(HALF - 13);
      end else begin
         wait_cyc(HALF);
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
      for (int i = 0; i < n; i++) ps2_bit(bits[i], i == glitch_at);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input int glitch_at);
      send_bits({1'b1, par, d, 1'b0}, 11, glitch_at);
   endtask

   task automatic check_sb_empty(input string name);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d codes still expected, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cyc(4);
      total++;
      if ({code, code_valid, frame_err, overrun, ps2_clk_pulldown} !== 12'h0) begin
         bad++;
         $display("FAIL reset_outputs: got code=%02h v=%b e=%b o=%b p=%b required all 0",
                  code, code_valid, frame_err, overrun, ps2_clk_pulldown);
      end
      rst = 1'b0;
      wait_cyc(20);
   endtask

   task automatic test_good_frame();
      int e0, v0;
      e0 = err_cnt; v0 = vld_cyc;
      code_ready = 1'b1;
      sb.push_back(8'h1C);
      send_frame(8'h1C, par_of(8'h1C), -1);
      wait_cyc(20);
      check_sb_empty("good_consumed");
      total++;
      if (code !== 8'h1C) begin bad++; $display("FAIL good_code: got %02h required 1c", code); end
      total++;
      if (vld_cyc - v0 != 1) begin bad++; $display("FAIL good_valid_len: got %0d cycles required 1", vld_cyc - v0); end
      total++;
      if (err_cnt != e0) begin bad++; $display("FAIL good_no_err: got %0d errors required 0", err_cnt - e0); end
   endtask

   task automatic test_parity_err();
      int e0, v0;
      e0 = err_cnt; v0 = vld_cyc;
      send_frame(8'h1C, 1'b1, -1);
      wait_cyc(20);
      total++;
      if (err_cnt - e0 != 1) begin bad++; $display("FAIL parity_err_count: got %0d required 1", err_cnt - e0); end
      total++;
      if (vld_cyc != v0) begin bad++; $display("FAIL parity_no_valid: got %0d valid cycles required 0", vld_cyc - v0); end
      total++;
      if (code !== 8'h1C) begin bad++; $display("FAIL parity_code_kept: got %02h required 1c", code); end
      sb.push_back(8'hF0);
      send_frame(8'hF0, par_of(8'hF0), -1);
      wait_cyc(20);
      check_sb_empty("parity_next_f0");
      total++;
      if (code !== 8'hF0) begin bad++; $display("FAIL parity_next_code: got %02h required f0", code); end
   endtask

   task automatic test_timeout();
      int e0, t;
      bit seen;
      e0 = err_cnt; seen = 0; t = 0;
      send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4, -1);
      for (int i = 0; i < TMO + 200 && !seen; i++) begin
         @(negedge clk);
         if (frame_err) begin seen = 1; t = cyc - last_fall; end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL timeout_seen: no frame_err within %0d cycles", TMO + 200);
      end else if (t < TMO || t > TMO + FILT + 6) begin
         bad++;
         $display("FAIL timeout_delay: got %0d cycles required %0d..%0d", t, TMO, TMO + FILT + 6);
      end
      @(posedge clk); #1;
      wait_cyc(20);
      total++;
      if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout_err_count: got %0d required 1", err_cnt - e0); end
      ps2_data = 1'b1;
      sb.push_back(8'h5A);
      send_frame(8'h5A, par_of(8'h5A), -1);
      wait_cyc(20);
      check_sb_empty("timeout_next_5a");
      total++;
      if (code !== 8'h5A) begin bad++; $display("FAIL timeout_next_code: got %02h required 5a", code); end
   endtask

   task automatic test_inhibit();
      int o0, e0;
      e0 = err_cnt;
      code_ready = 1'b0;
      sb.push_back(8'h1C);
      send_frame(8'h1C, par_of(8'h1C), -1);
      wait_cyc(5);
      total++;
      if (code_valid !== 1'b1 || ps2_clk_pulldown !== 1'b1 || code !== 8'h1C) begin
         bad++;
         $display("FAIL inhibit_hold: got v=%b p=%b code=%02h required v=1 p=1 code=1c",
                  code_valid, ps2_clk_pulldown, code);
      end
      o0 = ovr_cnt;
      send_frame(8'h5A, par_of(8'h5A), -1);
      wait_cyc(5);
      total++;
      if (ovr_cnt - o0 != 1) begin bad++; $display("FAIL overrun_count: got %0d required 1", ovr_cnt - o0); end
      total++;
      if (code !== 8'h1C || code_valid !== 1'b1) begin
         bad++;
         $display("FAIL overrun_code_kept: got code=%02h v=%b required 1c v=1", code, code_valid);
      end
      code_ready = 1'b1;
      wait_cyc(1);
      total++;
      if (code_valid !== 1'b0 || ps2_clk_pulldown !== 1'b0) begin
         bad++;
         $display("FAIL inhibit_release: got v=%b p=%b required 0 0", code_valid, ps2_clk_pulldown);
      end
      check_sb_empty("inhibit_consumed");
      total++;
      if (err_cnt != e0) begin bad++; $display("FAIL inhibit_no_err: got %0d errors required 0", err_cnt - e0); end
   endtask

   task automatic test_glitch();
      int e0;
      e0 = err_cnt;
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
      sb.push_back(8'h1C);
      send_frame(8'h1C, par_of(8'h1C), 3);
      wait_cyc(20);
      check_sb_empty("glitch_frame");
      total++;
      if (err_cnt != e0) begin bad++; $display("FAIL glitch_no_err: got %0d errors required 0", err_cnt - e0); end
      total++;
      if (code !== 8'h1C) begin bad++; $display("FAIL glitch_code: got %02h required 1c", code); end
   endtask

   task automatic test_rst_mid_frame();
      int e0;
      e0 = err_cnt;
      send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 6, -1);
      rst = 1'b1;
      wait_cyc(4);
      total++;
      if ({code, code_valid, frame_err, overrun, ps2_clk_pulldown} !== 12'h0) begin
         bad++;
         $display("FAIL rst_mid_outputs: got code=%02h v=%b e=%b o=%b p=%b required all 0",
                  code, code_valid, frame_err, overrun, ps2_clk_pulldown);
      end
      rst = 1'b0;
      ps2_data = 1'b1;
      wait_cyc(20);
      code_ready = 1'b0;
      sb.push_back(8'h5A);
      send_frame(8'h5A, par_of(8'h5A), -1);
      wait_cyc(20);
      total++;
      if (code_valid !== 1'b1 || code !== 8'h5A) begin
         bad++;
         $display("FAIL rst_next_frame: got code=%02h v=%b required 5a v=1", code, code_valid);
      end
      total++;
      if (err_cnt != e0) begin bad++; $display("FAIL rst_no_err: got %0d errors required 0", err_cnt - e0); end
      code_ready = 1'b1;
      wait_cyc(3);
      check_sb_empty("rst_next_consumed");
   endtask

   initial begin
      rst        = 1'b1;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      code_ready = 1'b1;
      test_reset();
      test_good_frame();
      test_parity_err();
      test_timeout();
      test_inhibit();
      test_glitch();
      test_rst_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host receiver, the stage directly upstream of the keyboard scan-code/ASCII logic and CPU interrupt logic.
- Synchronises and glitch-filters the open-collector ps2_clk/ps2_data lines.
- Deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) and checks them.
- Presents each good scan code on a one-entry valid/ready holding register.
- Inhibits the keyboard by pulling ps2_clk low while that register is full.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 20000: clk cycles without a ps2_clk falling edge, mid-frame, before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ps2_clk  in  1  raw PS/2 clock line (asynchronous)
- ps2_data  in  1  raw PS/2 data line (asynchronous)
- code_ready  in  1  downstream accepts code this cycle
- code  out  8  received scan code (holding register)
- code_valid  out  1  code holds an unconsumed byte
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error
- overrun  out  1  one-cycle pulse when a good byte is dropped because the holding register is full
- ps2_clk_pulldown  out  1  1 = drive ps2_clk low (inhibit)

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, filter level = 1, bit counter and timeout counter = 0, synchronisers = 1.
- Input path: 2-flop synchroniser on each line. ps2_clk then goes through a FILTER_LEN counter; the filtered level toggles only after FILTER_LEN equal samples.
- fall_strobe: one-cycle pulse when the filtered clock goes 1 to 0. Data is sampled from the synchronised ps2_data on fall_strobe.
- FSM states IDLE, RECV, CHECK:
  - IDLE: fall_strobe with data=0 goes to RECV, bitcnt=0. fall_strobe with data=1 pulses frame_err and stays in IDLE.
  - RECV: on each fall_strobe, bits 0..7 shift into the shift register LSB-first; bitcnt 8 captures parity; bitcnt 9 captures stop and goes to CHECK.
  - CHECK (one cycle): good when XOR(data[7:0], parity) = 1 and stop = 1.
    - Good and code_valid=0, or good and code_ready=1 this cycle: load code, code_valid=1 next cycle.
    - Good, code_valid=1 and code_ready=0: drop the byte and pulse overrun.
    - Bad: pulse frame_err; code is unchanged.
    - Always returns to IDLE.
- Latency: code_valid rises 2 clk cycles after the fall_strobe of the stop bit.
- Timeout: the counter clears on every fall_strobe and in IDLE. In RECV, reaching TIMEOUT_CYCLES pulses frame_err and returns to IDLE; partial data is discarded.
- Handshake:
  - code_valid && code_ready consumes the byte; code_valid falls next cycle unless CHECK reloads in the same cycle, in which case it stays 1 with the new code.
  - code stays stable while code_valid=1 and code_ready=0.
- Inhibit: ps2_clk_pulldown = 1 (registered) when state == IDLE && code_valid == 1. It releases the cycle after consumption. Frames already in progress are never inhibited; they complete and may overrun.
- Receive-only: this block never drives ps2_data; the top level ties ps2_data_pulldown to 0.
- Reset asserted mid-frame aborts the frame with no frame_err pulse. The next clean frame after reset deasserts decodes normally.
- frame_err and overrun are never asserted in the same cycle.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE/RECV/CHECK)
  - FRAME_DATA_BITS=8
  - PARITY_IDX=8, STOP_IDX=9
  - function odd_parity_ok(data, parity)
- Sub-module ps2_line_filter: synchroniser, FILTER_LEN glitch filter and fall_strobe generation for ps2_clk. ps2_data uses only a plain 2-flop synchroniser.

Test Plan:
- Good frame 0x1C (bits 0,00111000,0,1), code_ready=1 -> code=0x1C, code_valid high 1 cycle, frame_err=0.
- Frame 0x1C with parity bit 1 -> one frame_err pulse, code_valid stays 0, code unchanged; following good 0xF0 (parity 1) -> code=0xF0.
- Start bit plus 3 data bits, then clock idle -> frame_err exactly TIMEOUT_CYCLES after the last falling edge, FSM back to IDLE; next 0x5A frame decodes to 0x5A.
- code_ready=0, send 0x1C -> code_valid=1, ps2_clk_pulldown=1 once IDLE. Raise code_ready -> code_valid=0 and pulldown=0 one cycle later. Second frame sent while held (started before inhibit) -> overrun pulse, code remains 0x1C.
- 3-cycle low glitch on ps2_clk (< FILTER_LEN) in IDLE and mid-frame -> no bit sampled; the frame still decodes correctly (0x1C).
- Assert rst after 5 data bits of a frame -> all outputs 0, no frame_err. Then full 0x5A frame (parity 1) -> code=0x5A, code_valid=1.
